// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited memory requests, in-order
// instruction queue toward the decoder, and redirect flush with stale-response dropping.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [PtrW-1:0] ptr_t;

  logic [31:0] pc_q, pc_d;
  cnt_t        count_q, count_d;
  cnt_t        outst_q, outst_d;
  cnt_t        drop_q, drop_d;
  ptr_t        q_rd_q, q_rd_d, q_wr_q, q_wr_d;
  ptr_t        pp_rd_q, pp_rd_d, pp_wr_q, pp_wr_d;
  logic [31:0] q_data_q [DEPTH];
  logic [31:0] q_pc_q   [DEPTH];
  logic [31:0] pp_q     [DEPTH];

  logic [CntW:0] used;
  logic          req_fire, rsp_drop, enq, deq;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Queued entries plus in-flight requests never exceed DEPTH, so a response always has room.
  assign used           = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = !rst && !redirect && (used < (CntW+1)'(DEPTH));
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign enq      = imem_rsp_valid && (drop_q == '0) && !redirect;

  assign instr_valid = (count_q != '0);
  assign instruction = instr_valid ? q_data_q[q_rd_q] : Nop;
  assign instr_pc    = instr_valid ? q_pc_q[q_rd_q] : 32'h0;
  assign deq         = instr_valid && instr_ready && !redirect;

  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    count_d = count_q;
    q_rd_d  = q_rd_q;
    q_wr_d  = q_wr_q;
    pp_rd_d = pp_rd_q;
    pp_wr_d = pp_wr_q;

    if (req_fire) begin
      pc_d    = pc_q + 32'd4;
      outst_d = outst_d + cnt_t'(1);
      pp_wr_d = pp_wr_q + ptr_t'(1);
    end
    if (imem_rsp_valid && (outst_q != '0)) begin
      outst_d = outst_d - cnt_t'(1);
      pp_rd_d = pp_rd_q + ptr_t'(1);
    end
    if (rsp_drop) begin
      drop_d = drop_q - cnt_t'(1);
    end

    if (enq) begin
      q_wr_d  = q_wr_q + ptr_t'(1);
      count_d = count_d + cnt_t'(1);
    end
    if (deq) begin
      q_rd_d  = q_rd_q + ptr_t'(1);
      count_d = count_d - cnt_t'(1);
    end

    // Everything still in flight after this cycle belongs to the old stream.
    if (redirect) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      drop_d  = outst_d;
      count_d = '0;
      q_rd_d  = '0;
      q_wr_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      q_rd_q  <= '0;
      q_wr_q  <= '0;
      pp_rd_q <= '0;
      pp_wr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data_q[i] <= Nop;
        q_pc_q[i]   <= 32'h0;
        pp_q[i]     <= 32'h0;
      end
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      q_rd_q  <= q_rd_d;
      q_wr_q  <= q_wr_d;
      pp_rd_q <= pp_rd_d;
      pp_wr_q <= pp_wr_d;
      if (req_fire) begin
        pp_q[pp_wr_q] <= pc_q;
      end
      if (enq) begin
        q_data_q[q_wr_q] <= imem_rsp_data;
        q_pc_q[q_wr_q]   <= pp_q[pp_rd_q];
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) enq |-> (count_q != cnt_t'(DEPTH)));
  assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> (outst_q != '0));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the RV32I decoder.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel.
- Buffers returned words with their PCs in a small in-order queue and presents them to the decoder with a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution and flushes all stale fetches.

Parameters:
- DEPTH, 2: instruction queue entries; also the maximum number of requests in flight plus entries held (power of two, ≥2).
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  32  request word address (bits[1:0] always 0).
- imem_rsp_valid  in  1  response data valid; responses return in request order, ≥1 cycle after acceptance, never stalled.
- imem_rsp_data  in  32  returned instruction word.
- redirect  in  1  PC redirect (taken branch, JAL, JALR).
- redirect_pc  in  32  new fetch address; bits[1:0] ignored (treated as 0).
- instr_valid  out  1  queue head valid toward decoder.
- instr_ready  in  1  decoder consumes head this cycle.
- instruction  out  32  head instruction word; 32'h0000_0013 (NOP) when instr_valid=0.
- instr_pc  out  32  PC of head instruction; 0 when instr_valid=0.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0.
  - instr_valid=0, instruction=NOP, instr_pc=0, imem_req_valid=0.
- Credit rule:
  - imem_req_valid = !redirect && (count + outstanding < DEPTH); imem_addr = pc.
  - Request accepted when imem_req_valid && imem_req_ready: pc += 4 (32-bit wrap from FFFF_FFFC to 0), outstanding += 1.
- Pending-PC FIFO: an internal DEPTH-entry FIFO records the address of each accepted request. Its head pairs with the next response.
- Response handling:
  - If drop_cnt > 0: discard the response; drop_cnt -= 1; outstanding -= 1.
  - Otherwise: enqueue {data, pc} and decrement outstanding.
  - The credit rule guarantees the queue is never full on a response. An enqueue into a full queue is an assertion failure.
- Dequeue on instr_valid && instr_ready. Enqueue and dequeue in the same cycle both occur; count unchanged.
- Latency: response accepted in cycle N appears on instr_valid at cycle N+1 (registered queue output; no response-to-output bypass).
- Redirect (single cycle, highest priority):
  - Next cycle pc = {redirect_pc[31:2], 2'b00}.
  - Queue emptied; any dequeue that cycle is ignored.
  - drop_cnt = outstanding after that cycle's updates, so every in-flight response, including one arriving in the redirect cycle, is dropped. The redirect cycle itself issues no request.
  - First request to the new PC is issued the cycle after redirect.
  - Back-to-back redirects: the last one wins. drop_cnt accumulates correctly because no new requests are issued during redirect cycles.
- imem_req_ready low holds imem_addr and imem_req_valid stable unless a redirect occurs.
- Counters are $clog2(DEPTH)+1 bits wide and never underflow. A response with outstanding=0 is an assertion failure.
- Reset mid-operation: all in-flight state is discarded immediately. Responses arriving after reset deassertion for pre-reset requests are a memory-side protocol violation and out of scope.

Test Plan:
- Reset, imem_req_ready=1, 1-cycle memory, instr_ready=1 -> addresses 0,4,8,C issued. instr_pc/instruction stream 0,4,8,C paired with their memory words; first instr_valid 2 cycles after reset release.
- instr_ready=0 for 10 cycles, DEPTH=2 -> exactly 2 requests accepted, then imem_req_valid=0. Queue holds PCs 0,4. Releasing instr_ready delivers 0,4 in order, then fetch resumes at 8.
- Memory latency 3, redirect to 32'h0000_0102 with 2 requests outstanding -> both responses dropped. Next imem_addr = 0x100. First instr_pc after redirect = 0x100.
- Redirect in the same cycle as a response and a dequeue -> response not enqueued, dequeue ignored, queue empty next cycle. No instruction from the old stream ever reaches the decoder.
- imem_req_ready low for 5 cycles -> imem_addr held constant, no PC advance, instr_valid drains to 0. instruction reads 32'h0000_0013.
- Assert rst mid-stream with queue full -> same cycle: instr_valid=0, imem_req_valid=0. After release, first imem_addr = RESET_PC.
